// File: rtl/dio_bus_ctrl.sv
// Data/IO bus controller: request/ready data port, single-cycle IO port, pipeline stall.
// Optional wait timeout with sticky bus_error when DIO_TIMEOUT_EN is defined.
module dio_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ren,
  input  logic        data_wren,
  input  logic        IO_ren,
  input  logic        IO_wren,
  input  logic [31:0] data_address,
  input  logic [15:0] IO_address,
  input  logic [15:0] DIO_out,
  output logic [15:0] DIO_in,
  output logic        data_hazard,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        io_ren,
  output logic        io_wen,
  output logic [15:0] io_addr,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata,
  output logic        bus_error,
  output logic [0:0]  state_dbg
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_MEM_WAIT = 1'b1;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("dio_bus_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  logic [0:0] state;
  logic       data_strobe;
  logic       io_sel;

  // Handshake: mem_req rises with the latched request and stays high, with
  // address/data/we frozen, until the cycle mem_ready is seen (or the wait
  // is aborted); mem_ready outside MEM_WAIT is ignored.
  assign data_strobe = data_ren | data_wren;
  assign io_sel      = (state == S_IDLE) && !data_strobe;
  assign io_ren      = io_sel & IO_ren;
  assign io_wen      = io_sel & IO_wren;
  assign io_addr     = IO_address;
  assign io_wdata    = DIO_out;
  assign data_hazard = (state == S_MEM_WAIT);
  assign state_dbg   = state;

`ifdef DIO_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
  logic       timeout_hit;

  // Counter reaching TIMEOUT_CYCLES at this edge; a coincident ready wins.
  assign timeout_hit = (state == S_MEM_WAIT) && !mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= 8'd0;
      bus_error <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        wait_cnt <= 8'd0;
      end else if (!mem_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (timeout_hit) begin
        bus_error <= 1'b1;
      end
    end
  end
`else
  logic timeout_hit;
  assign timeout_hit = 1'b0;
  assign bus_error   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      DIO_in    <= 16'h0000;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (data_strobe) begin
            // Store wins when both data strobes are set.
            mem_addr  <= data_address;
            mem_wdata <= DIO_out;
            mem_we    <= data_wren;
            mem_req   <= 1'b1;
            state     <= S_MEM_WAIT;
          end else if (IO_ren) begin
            DIO_in <= io_rdata;
          end
        end
        S_MEM_WAIT: begin
          if (mem_ready) begin
            if (!mem_we) begin
              DIO_in <= mem_rdata;
            end
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end else if (timeout_hit) begin
            if (!mem_we) begin
              DIO_in <= 16'hFFFF;
            end
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
